// File: rtl/riscv_defs_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : riscv_defs (package)
// Brief    : Shared RISC-V decode constants and branch-predictor helpers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package riscv_defs;

   // RV32I conditional branch major opcode
   localparam logic [6:0] c_opcode_branch = 7'b1100011;

   // Saturating counters come out of reset at the weakly-taken midpoint
   function automatic logic [3:0] cnt_reset_val(input int cnt_width);
      cnt_reset_val = 4'(1 << (cnt_width - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/bht_counter_table.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : bht_counter_table
// Brief    : Array of saturating up/down counters, one async read port
//            (MSB only) and one synchronous saturating update port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module bht_counter_table
   import riscv_defs::*;
#(
   parameter int DEPTH     = 64,
   parameter int CNT_WIDTH = 2,
   parameter int IDX_W     = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
   localparam logic [CNT_WIDTH-1:0] c_cnt_rst = CNT_WIDTH'(cnt_reset_val(CNT_WIDTH));

   logic [CNT_WIDTH-1:0] cnt_q [DEPTH];
   logic [CNT_WIDTH-1:0] cnt_d [DEPTH];
   logic [CNT_WIDTH-1:0] cur_cnt;

   // Read returns the registered value, so a same-cycle update is not bypassed
   assign rd_taken = cnt_q[rd_idx][CNT_WIDTH-1];

   // Next-state: step the addressed counter toward the outcome, clamped at both ends
   always_comb begin
      cnt_d   = cnt_q;
      cur_cnt = cnt_q[upd_idx];
      if (upd_en) begin
         if (upd_taken && (cur_cnt != c_cnt_max)) begin
            cnt_d[upd_idx] = cur_cnt + 1'b1;
         end else if (!upd_taken && (cur_cnt != '0)) begin
            cnt_d[upd_idx] = cur_cnt - 1'b1;
         end
      end
   end

   // Counter storage, weakly taken out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            cnt_q[i] <= c_cnt_rst;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bht_predictor.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : bht_predictor
// Brief    : Branch history table predictor. Predicts conditional branches in
//            ID, resolves them in EX, produces redirect fixes and statistics.
//            Define BHT_PREDICTOR_GSHARE_EN to XOR a non-speculative global
//            history register into the table index (gshare).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module bht_predictor
   import riscv_defs::*;
#(
   parameter int INST_ADDR_WIDTH = 32,
   parameter int BHT_DEPTH       = 64,
   parameter int CNT_WIDTH       = 2,
   parameter int GHR_WIDTH       = 6
) (
   input  logic                       cpu_clk,
   input  logic                       cpu_rst,
   input  logic [6:0]                 opcode_ID,
   input  logic [INST_ADDR_WIDTH-1:0] PC_ID,
   input  logic [INST_ADDR_WIDTH-1:0] imm_ID,
   input  logic [6:0]                 opcode_EX,
   input  logic [INST_ADDR_WIDTH-1:0] PC_EX,
   input  logic [INST_ADDR_WIDTH-1:0] PC_plus_4_EX,
   input  logic [INST_ADDR_WIDTH-1:0] imm_EX,
   input  logic                       branch_res_EX,
   input  logic                       stall_ID,
   input  logic                       flush_ID,
   output logic                       predict_branch_taken_ID,
   output logic [INST_ADDR_WIDTH-1:0] predict_branch_taken_PC_ID,
   output logic                       fix_predict_EX,
   output logic [INST_ADDR_WIDTH-1:0] fix_predict_PC_EX,
   output logic [31:0]                num_branch,
   output logic [31:0]                num_fault
);

   localparam int c_idx_w = $clog2(BHT_DEPTH);

   // Reject configurations the index arithmetic cannot support
   generate
      if ((BHT_DEPTH < 4) || ((BHT_DEPTH & (BHT_DEPTH - 1)) != 0) ||
          (CNT_WIDTH < 1) || (CNT_WIDTH > 4) ||
          (GHR_WIDTH < 1) || (GHR_WIDTH > c_idx_w)) begin : g_bad_params
         $error("bht_predictor: illegal parameter combination");
      end
   endgenerate

   logic [c_idx_w-1:0] idx_id;
   logic               rd_taken;
   logic               is_br_id;
   logic               pred_id;

   // ID->EX prediction register
   logic               valid_q, valid_d;
   logic               pred_q,  pred_d;
   logic [c_idx_w-1:0] idx_q,   idx_d;

   logic               resolve_ex;
   logic               mispredict_ex;
   logic [31:0]        num_branch_q, num_branch_d;
   logic [31:0]        num_fault_q,  num_fault_d;

   // A branch held in EX by a stall resolves only on the releasing edge
   assign resolve_ex    = valid_q && (opcode_EX == c_opcode_branch) && !stall_ID;
   assign mispredict_ex = resolve_ex && (pred_q != branch_res_EX);

`ifdef BHT_PREDICTOR_GSHARE_EN
   logic [GHR_WIDTH-1:0] ghr_q, ghr_d;

   assign idx_id = PC_ID[c_idx_w+1:2] ^ c_idx_w'(ghr_q);

   // History advances only on resolved outcomes (non-speculative)
   always_comb begin
      ghr_d = ghr_q;
      if (resolve_ex) begin
         ghr_d = GHR_WIDTH'({ghr_q, branch_res_EX});
      end
   end

   // Global history register
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end
`else
   assign idx_id = PC_ID[c_idx_w+1:2];
`endif

   bht_counter_table #(
      .DEPTH     (BHT_DEPTH),
      .CNT_WIDTH (CNT_WIDTH),
      .IDX_W     (c_idx_w)
   ) u_table (
      .clk       (cpu_clk),
      .rst       (cpu_rst),
      .rd_idx    (idx_id),
      .rd_taken  (rd_taken),
      .upd_en    (resolve_ex),
      .upd_idx   (idx_q),
      .upd_taken (branch_res_EX)
   );

   assign is_br_id = (opcode_ID == c_opcode_branch);
   assign pred_id  = is_br_id && rd_taken;

   assign predict_branch_taken_ID    = pred_id;
   assign predict_branch_taken_PC_ID = pred_id ? (PC_ID + imm_ID) : '0;

   // Redirect target is the path the prediction did not take
   assign fix_predict_EX    = mispredict_ex;
   assign fix_predict_PC_EX = !mispredict_ex ? '0 :
                              pred_q         ? PC_plus_4_EX : (PC_EX + imm_EX);

   assign num_branch = num_branch_q;
   assign num_fault  = num_fault_q;

   // Next-state for the ID->EX register: flush beats stall, stall holds
   always_comb begin
      valid_d = valid_q;
      pred_d  = pred_q;
      idx_d   = idx_q;
      if (flush_ID) begin
         valid_d = 1'b0;
      end else if (!stall_ID) begin
         valid_d = is_br_id;
         pred_d  = pred_id;
         idx_d   = idx_id;
      end
   end

   // Statistics counters, free-running wrap
   always_comb begin
      num_branch_d = num_branch_q + (resolve_ex    ? 32'd1 : 32'd0);
      num_fault_d  = num_fault_q  + (mispredict_ex ? 32'd1 : 32'd0);
   end

   // Pipeline register and statistics state
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         valid_q      <= 1'b0;
         pred_q       <= 1'b0;
         idx_q        <= '0;
         num_branch_q <= '0;
         num_fault_q  <= '0;
      end else begin
         valid_q      <= valid_d;
         pred_q       <= pred_d;
         idx_q        <= idx_d;
         num_branch_q <= num_branch_d;
         num_fault_q  <= num_fault_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bht_predictor.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_bht_predictor
// Brief    : Directed self-checking bench for bht_predictor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bht_predictor;

   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] NOP = 7'b0010011;

   logic        cpu_clk;
   logic        cpu_rst;
   logic [6:0]  opcode_ID;
   logic [31:0] PC_ID, imm_ID;
   logic [6:0]  opcode_EX;
   logic [31:0] PC_EX, PC_plus_4_EX, imm_EX;
   logic        branch_res_EX, stall_ID, flush_ID;
   logic        predict_branch_taken_ID;
   logic [31:0] predict_branch_taken_PC_ID;
   logic        fix_predict_EX;
   logic [31:0] fix_predict_PC_EX;
   logic [31:0] num_branch, num_fault;

   int checks = 0;
   int errors = 0;

   bht_predictor dut (
      .cpu_clk                    (cpu_clk),
      .cpu_rst                    (cpu_rst),
      .opcode_ID                  (opcode_ID),
      .PC_ID                      (PC_ID),
      .imm_ID                     (imm_ID),
      .opcode_EX                  (opcode_EX),
      .PC_EX                      (PC_EX),
      .PC_plus_4_EX               (PC_plus_4_EX),
      .imm_EX                     (imm_EX),
      .branch_res_EX              (branch_res_EX),
      .stall_ID                   (stall_ID),
      .flush_ID                   (flush_ID),
      .predict_branch_taken_ID    (predict_branch_taken_ID),
      .predict_branch_taken_PC_ID (predict_branch_taken_PC_ID),
      .fix_predict_EX             (fix_predict_EX),
      .fix_predict_PC_EX          (fix_predict_PC_EX),
      .num_branch                 (num_branch),
      .num_fault                  (num_fault)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   task automatic step();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic set_id(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm);
      opcode_ID = op; PC_ID = pc; imm_ID = imm;
   endtask

   task automatic set_ex(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm, input logic res);
      opcode_EX = op; PC_EX = pc; PC_plus_4_EX = pc + 32'd4; imm_EX = imm; branch_res_EX = res;
   endtask

   task automatic test_reset();
      cpu_rst = 1'b1; stall_ID = 1'b0; flush_ID = 1'b0;
      set_id(BR, 32'h100, 32'h20);
      set_ex(NOP, 32'h0, 32'h0, 1'b0);
      step(); step();
      checks++; if (predict_branch_taken_ID !== 1'b1) begin errors++; $display("FAIL rst_pred got %b exp 1", predict_branch_taken_ID); end
      checks++; if (predict_branch_taken_PC_ID !== 32'h120) begin errors++; $display("FAIL rst_pred_pc got %h exp 120", predict_branch_taken_PC_ID); end
      checks++; if (fix_predict_EX !== 1'b0 || fix_predict_PC_EX !== 32'h0) begin errors++; $display("FAIL rst_fix got %b/%h exp 0/0", fix_predict_EX, fix_predict_PC_EX); end
      checks++; if (num_branch !== 32'd0 || num_fault !== 32'd0) begin errors++; $display("FAIL rst_stats got %0d/%0d exp 0/0", num_branch, num_fault); end
      checks++; if (dut.u_table.cnt_q[0] !== 2'd2 || dut.u_table.cnt_q[63] !== 2'd2) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 2/2", dut.u_table.cnt_q[0], dut.u_table.cnt_q[63]); end
      cpu_rst = 1'b0;
      #1;
      checks++; if (predict_branch_taken_ID !== 1'b1 || predict_branch_taken_PC_ID !== 32'h120) begin errors++; $display("FAIL post_rst_pred got %b/%h exp 1/120", predict_branch_taken_ID, predict_branch_taken_PC_ID); end
      set_id(NOP, 32'h0, 32'h0);
      step();
   endtask

   // idx 0: 2 -> 1 (fault) -> 0 (no fault), third fetch not taken
   task automatic test_mispredict();
      set_id(BR, 32'h100, 32'h20); step();
      set_id(NOP, 32'h0, 32'h0); set_ex(BR, 32'h100, 32'h20, 1'b0); #1;
      checks++; if (fix_predict_EX !== 1'b1 || fix_predict_PC_EX !== 32'h104) begin errors++; $display("FAIL mis_fix1 got %b/%h exp 1/104", fix_predict_EX, fix_predict_PC_EX); end
      step();
      set_ex(NOP, 32'h0, 32'h0, 1'b0); set_id(BR, 32'h100, 32'h20); #1;
      checks++; if (predict_branch_taken_ID !== 1'b0 || predict_branch_taken_PC_ID !== 32'h0) begin errors++; $display("FAIL mis_pred2 got %b/%h exp 0/0", predict_branch_taken_ID, predict_branch_taken_PC_ID); end
      step();
      set_id(NOP, 32'h0, 32'h0); set_ex(BR, 32'h100, 32'h20, 1'b0); #1;
      checks++; if (fix_predict_EX !== 1'b0 || fix_predict_PC_EX !== 32'h0) begin errors++; $display("FAIL mis_fix2 got %b/%h exp 0/0", fix_predict_EX, fix_predict_PC_EX); end
      step();
      set_ex(NOP, 32'h0, 32'h0, 1'b0); set_id(BR, 32'h100, 32'h20); #1;
      checks++; if (predict_branch_taken_ID !== 1'b0) begin errors++; $display("FAIL mis_pred3 got %b exp 0", predict_branch_taken_ID); end
      checks++; if (num_fault !== 32'd1 || num_branch !== 32'd2) begin errors++; $display("FAIL mis_stats got %0d/%0d exp 2/1", num_branch, num_fault); end
      checks++; if (dut.u_table.cnt_q[0] !== 2'd0) begin errors++; $display("FAIL mis_cnt got %0d exp 0", dut.u_table.cnt_q[0]); end
      step();
      set_id(NOP, 32'h0, 32'h0); step();
   endtask

   // idx 16 (PC 0x40): 2 -> 3, then saturates over four more taken
   task automatic test_saturate();
      for (int k = 1; k <= 5; k++) begin
         set_id(BR, 32'h40, 32'h10); #1;
         checks++; if (predict_branch_taken_ID !== 1'b1) begin errors++; $display("FAIL sat_pred%0d got %b exp 1", k, predict_branch_taken_ID); end
         step();
         set_id(NOP, 32'h0, 32'h0); set_ex(BR, 32'h40, 32'h10, 1'b1); #1;
         checks++; if (fix_predict_EX !== 1'b0) begin errors++; $display("FAIL sat_fix%0d got %b exp 0", k, fix_predict_EX); end
         step();
         set_ex(NOP, 32'h0, 32'h0, 1'b0);
         checks++; if (dut.u_table.cnt_q[16] !== 2'd3) begin errors++; $display("FAIL sat_cnt%0d got %0d exp 3", k, dut.u_table.cnt_q[16]); end
      end
      checks++; if (num_branch !== 32'd7 || num_fault !== 32'd1) begin errors++; $display("FAIL sat_stats got %0d/%0d exp 7/1", num_branch, num_fault); end
   endtask

   // idx 32 (PC 0x80)
   task automatic test_flush();
      set_id(BR, 32'h80, 32'h8); flush_ID = 1'b1; step();
      flush_ID = 1'b0; set_id(NOP, 32'h0, 32'h0); set_ex(BR, 32'h80, 32'h8, 1'b0); #1;
      checks++; if (fix_predict_EX !== 1'b0 || fix_predict_PC_EX !== 32'h0) begin errors++; $display("FAIL flush_fix got %b/%h exp 0/0", fix_predict_EX, fix_predict_PC_EX); end
      step();
      set_ex(NOP, 32'h0, 32'h0, 1'b0);
      checks++; if (num_branch !== 32'd7 || dut.u_table.cnt_q[32] !== 2'd2) begin errors++; $display("FAIL flush_noupd got %0d/%0d exp 7/2", num_branch, dut.u_table.cnt_q[32]); end
      // flush wins over stall
      set_id(BR, 32'h80, 32'h8); step();
      set_id(NOP, 32'h0, 32'h0); flush_ID = 1'b1; stall_ID = 1'b1; step();
      flush_ID = 1'b0; stall_ID = 1'b0; set_ex(BR, 32'h80, 32'h8, 1'b0); #1;
      checks++; if (fix_predict_EX !== 1'b0) begin errors++; $display("FAIL flush_prio got %b exp 0", fix_predict_EX); end
      step();
      set_ex(NOP, 32'h0, 32'h0, 1'b0);
      checks++; if (num_branch !== 32'd7 || dut.u_table.cnt_q[32] !== 2'd2) begin errors++; $display("FAIL flush_prio_noupd got %0d/%0d exp 7/2", num_branch, dut.u_table.cnt_q[32]); end
   endtask

   // idx 48 (PC 0xC0)
   task automatic test_stall();
      set_id(BR, 32'hC0, 32'h40); step();
      set_id(NOP, 32'h0, 32'h0); set_ex(BR, 32'hC0, 32'h40, 1'b0); stall_ID = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (fix_predict_EX !== 1'b0) begin errors++; $display("FAIL stall_fix%0d got %b exp 0", k, fix_predict_EX); end
         step();
      end
      checks++; if (num_branch !== 32'd7 || dut.u_table.cnt_q[48] !== 2'd2) begin errors++; $display("FAIL stall_hold got %0d/%0d exp 7/2", num_branch, dut.u_table.cnt_q[48]); end
      stall_ID = 1'b0; #1;
      checks++; if (fix_predict_EX !== 1'b1 || fix_predict_PC_EX !== 32'hC4) begin errors++; $display("FAIL stall_rel_fix got %b/%h exp 1/c4", fix_predict_EX, fix_predict_PC_EX); end
      step();
      checks++; if (fix_predict_EX !== 1'b0) begin errors++; $display("FAIL stall_once got %b exp 0", fix_predict_EX); end
      step();
      set_ex(NOP, 32'h0, 32'h0, 1'b0);
      checks++; if (num_branch !== 32'd8 || num_fault !== 32'd2 || dut.u_table.cnt_q[48] !== 2'd1) begin errors++; $display("FAIL stall_upd got %0d/%0d/%0d exp 8/2/1", num_branch, num_fault, dut.u_table.cnt_q[48]); end
   endtask

   // idx 0 starts at 0; same-cycle ID read sees pre-update value
   task automatic test_back_to_back();
      set_id(BR, 32'h100, 32'h20); step();
      set_ex(BR, 32'h100, 32'h20, 1'b1); #1;
      checks++; if (predict_branch_taken_ID !== 1'b0 || fix_predict_EX !== 1'b1 || fix_predict_PC_EX !== 32'h120) begin errors++; $display("FAIL b2b_1 got %b/%b/%h exp 0/1/120", predict_branch_taken_ID, fix_predict_EX, fix_predict_PC_EX); end
      step();
      #1;
      checks++; if (predict_branch_taken_ID !== 1'b0 || fix_predict_EX !== 1'b1) begin errors++; $display("FAIL b2b_2 got %b/%b exp 0/1", predict_branch_taken_ID, fix_predict_EX); end
      step();
      #1;
      checks++; if (predict_branch_taken_ID !== 1'b1 || predict_branch_taken_PC_ID !== 32'h120 || fix_predict_EX !== 1'b1) begin errors++; $display("FAIL b2b_3 got %b/%h/%b exp 1/120/1", predict_branch_taken_ID, predict_branch_taken_PC_ID, fix_predict_EX); end
      step();
      set_id(NOP, 32'h0, 32'h0); #1;
      checks++; if (fix_predict_EX !== 1'b0) begin errors++; $display("FAIL b2b_4 got %b exp 0", fix_predict_EX); end
      step();
      set_ex(NOP, 32'h0, 32'h0, 1'b0);
      checks++; if (num_branch !== 32'd12 || num_fault !== 32'd5 || dut.u_table.cnt_q[0] !== 2'd3) begin errors++; $display("FAIL b2b_stats got %0d/%0d/%0d exp 12/5/3", num_branch, num_fault, dut.u_table.cnt_q[0]); end
   endtask

   task automatic test_reset_mid();
      set_id(BR, 32'h40, 32'h10); step();
      set_id(NOP, 32'h0, 32'h0); set_ex(BR, 32'h40, 32'h10, 1'b0); #1;
      checks++; if (fix_predict_EX !== 1'b1 || fix_predict_PC_EX !== 32'h44) begin errors++; $display("FAIL rmid_fix got %b/%h exp 1/44", fix_predict_EX, fix_predict_PC_EX); end
      #1 cpu_rst = 1'b1;
      #1;
      checks++; if (fix_predict_EX !== 1'b0 || num_branch !== 32'd0 || num_fault !== 32'd0) begin errors++; $display("FAIL rmid_async got %b/%0d/%0d exp 0/0/0", fix_predict_EX, num_branch, num_fault); end
      checks++; if (dut.u_table.cnt_q[16] !== 2'd2 || dut.u_table.cnt_q[0] !== 2'd2) begin errors++; $display("FAIL rmid_cnt got %0d/%0d exp 2/2", dut.u_table.cnt_q[16], dut.u_table.cnt_q[0]); end
      step();
      cpu_rst = 1'b0; #1;
      checks++; if (fix_predict_EX !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", fix_predict_EX); end
      step();
      set_ex(NOP, 32'h0, 32'h0, 1'b0);
      checks++; if (num_branch !== 32'd0 || dut.u_table.cnt_q[16] !== 2'd2) begin errors++; $display("FAIL rmid_discard got %0d/%0d exp 0/2", num_branch, dut.u_table.cnt_q[16]); end
   endtask

`ifdef BHT_PREDICTOR_GSHARE_EN
   // PC 0x100 and 0x200 alias to idx 0 without history; with GHR=1 the second maps to idx 1
   task automatic test_gshare();
      set_id(BR, 32'h100, 32'h20); step();
      set_id(NOP, 32'h0, 32'h0); set_ex(BR, 32'h100, 32'h20, 1'b1); step();
      set_ex(NOP, 32'h0, 32'h0, 1'b0); set_id(BR, 32'h200, 32'h20); #1;
      checks++; if (predict_branch_taken_ID !== 1'b1 || predict_branch_taken_PC_ID !== 32'h220) begin errors++; $display("FAIL gs_pred got %b/%h exp 1/220", predict_branch_taken_ID, predict_branch_taken_PC_ID); end
      step();
      set_id(NOP, 32'h0, 32'h0); set_ex(BR, 32'h200, 32'h20, 1'b0); #1;
      checks++; if (fix_predict_EX !== 1'b1 || fix_predict_PC_EX !== 32'h204) begin errors++; $display("FAIL gs_fix got %b/%h exp 1/204", fix_predict_EX, fix_predict_PC_EX); end
      step();
      set_ex(NOP, 32'h0, 32'h0, 1'b0);
      checks++; if (dut.u_table.cnt_q[0] !== 2'd3 || dut.u_table.cnt_q[1] !== 2'd1) begin errors++; $display("FAIL gs_entries got %0d/%0d exp 3/1", dut.u_table.cnt_q[0], dut.u_table.cnt_q[1]); end
   endtask
`endif

   initial begin
      test_reset();
      test_mispredict();
      test_saturate();
      test_flush();
      test_stall();
      test_back_to_back();
      test_reset_mid();
`ifdef BHT_PREDICTOR_GSHARE_EN
      test_gshare();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
